acc_file_pipe: RTL

- Parametrised accumulator register file: DEPTH entries of WIDTH bits, NUM_RD combinational read ports, one write/accumulate port.
- Write port supports LOAD, ADD, SUB and CLEAR-ALL, with optional saturation and per-entry sticky signed-overflow flags.
- Writes pass through one pipeline stage (S1) before commit, so the read-modify-write path is registered.
- Sits beside the datapath ALU as the accumulator bank; drives ALU operands via the read ports and takes results/immediates on the write port.

---
 rtl/acc_file_pipe.sv | 67 ++++++
 1 files changed

// File: rtl/acc_file_pipe.sv
// acc_file_pipe: pipelined accumulator register file with LOAD/ADD/SUB/CLR_ALL, sticky overflow, optional ACC_BYPASS_EN read forwarding
module acc_file_pipe #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int NUM_RD = 2,
  parameter int SAT    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [1:0]                    wr_op,
  input  logic [$clog2(DEPTH)-1:0]      wr_adr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          ovf_clr,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_adr,
  output logic [NUM_RD*WIDTH-1:0]       ac,
  output logic [DEPTH-1:0]              ovf,
  output logic                          pend
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLR = 2'b11;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             s1_v;
  logic [1:0]       s1_op;
  logic [AW-1:0]    s1_adr;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH:0]   a_x, d_x, sum;
  logic             ov;
  logic [WIDTH-1:0] res;
  assign pend = s1_v;
  always_comb begin
    a_x = {mem[s1_adr][WIDTH-1], mem[s1_adr]};
    d_x = {s1_data[WIDTH-1], s1_data};
    sum = s1_op == OP_SUB ? a_x - d_x : a_x + d_x;
    ov  = (s1_op == OP_ADD || s1_op == OP_SUB) && (sum[WIDTH] ^ sum[WIDTH-1]);
    res = s1_op == OP_LOAD ? s1_data :
          s1_op == OP_CLR  ? '0 :
          ov && SAT != 0   ? {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}} : sum[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      ovf  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      s1_v    <= wr_en;
      s1_op   <= wr_op;
      s1_adr  <= wr_adr;
      s1_data <= wr_data;
      if (s1_v) begin
        if (s1_op == OP_CLR) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else mem[s1_adr] <= res;
      end
      if (ovf_clr) ovf <= '0;
      if (s1_v && ov) ovf[s1_adr] <= 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_adr[g*AW +: AW];
`ifdef ACC_BYPASS_EN
    assign ac[g*WIDTH +: WIDTH] = s1_v && (s1_op == OP_CLR || s1_adr == ra) ? res : mem[ra];
`else
    assign ac[g*WIDTH +: WIDTH] = mem[ra];
`endif
  end
endmodule
